// File: rtl/mdu_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the HI/LO
// multiply/divide controller.
package mdu_ctrl_pkg;

    localparam logic [5:0] R_FORM = 6'h00;

    localparam logic [5:0] MFHI  = 6'h10;
    localparam logic [5:0] MTHI  = 6'h11;
    localparam logic [5:0] MFLO  = 6'h12;
    localparam logic [5:0] MTLO  = 6'h13;
    localparam logic [5:0] MULT  = 6'h18;
    localparam logic [5:0] MULTU = 6'h19;
    localparam logic [5:0] DIV   = 6'h1A;
    localparam logic [5:0] DIVU  = 6'h1B;

    localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        MDU_IDLE,
        MDU_MUL,
        MDU_DIV,
        MDU_FIX
    } mdu_state_e;

    function automatic logic [31:0] mag(
        input logic [31:0] v,
        input logic        sgn
    );
        return (sgn && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the shift-add multiplier or restoring divider,
// retiring STEP_BITS bits of the operation.
module mdu_step
    import mdu_ctrl_pkg::*;
#(
    parameter int STEP_BITS = 1
) (
    input  logic                 div_i,
    input  logic [63:0]          acc_i,
    input  logic [31:0]          opnd_i,
    output logic [63:0]          acc_o,
    output logic [STEP_BITS-1:0] q_o
);

    logic [33:0] sum;
    logic [31:0] rem;
    logic [31:0] dvd;
    logic [32:0] r33;

    always_comb begin
        acc_o = '0;
        q_o   = '0;
        sum   = '0;
        rem   = '0;
        dvd   = '0;
        r33   = '0;
        if (!div_i) begin
            // Upper half accumulates; lower half holds the unconsumed multiplier.
            sum = {2'b00, acc_i[63:32]};
            for (int i = 0; i < STEP_BITS; i++) begin
                if (acc_i[i]) begin
                    sum = sum + (34'(opnd_i) << i);
                end
            end
            acc_o = 64'({sum, acc_i[31:0]} >> STEP_BITS);
        end else begin
            rem = acc_i[63:32];
            dvd = acc_i[31:0];
            for (int i = 0; i < STEP_BITS; i++) begin
                r33 = {rem, dvd[31]};
                dvd = dvd << 1;
                if (r33 >= {1'b0, opnd_i}) begin
                    rem = 32'(r33 - {1'b0, opnd_i});
                    q_o[STEP_BITS-1-i] = 1'b1;
                end else begin
                    rem = r33[31:0];
                end
            end
            acc_o = {rem, dvd};
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller owning HI/LO for the EX stage.
// Stalls HI/LO consumers and new MDU ops while an operation is in flight.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int STEP_BITS = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Ins,
    input  logic        InsValid,
    input  logic [31:0] Rdata1,
    input  logic [31:0] Rdata2,
    output logic [31:0] HIout,
    output logic [31:0] LOout,
    output logic        Busy,
    output logic        Stall
);

    localparam int N = 32 / STEP_BITS;

    mdu_state_e  state_q;
    logic [5:0]  cnt_q;
    logic [63:0] acc_q;
    logic [31:0] opnd_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] dzhi_q;
    logic        neg_q;
    logic        rneg_q;
    logic        dz_q;
    logic        is_div_q;

    logic [5:0]  funct;
    logic        is_mdu;
    logic        busy;
    logic        accept;
    logic        sgn;
    logic        s1;
    logic        s2;
    logic        unused_ins;

    logic [63:0]          step_acc;
    logic [STEP_BITS-1:0] step_q;
    logic [63:0]          acc_d;
    logic [63:0]          prod;
    logic [31:0]          quo;
    logic [31:0]          rem;

    assign funct      = Ins[5:0];
    assign unused_ins = ^Ins[25:6];
    assign is_mdu     = (Ins[31:26] == R_FORM) &&
                        (funct inside {MULT, MULTU, DIV, DIVU,
                                       MTHI, MTLO, MFHI, MFLO});
    assign busy       = (state_q != MDU_IDLE);
    assign Stall      = InsValid & busy & is_mdu;
    assign accept     = InsValid & is_mdu & ~busy;
    assign sgn        = (funct == MULT) || (funct == DIV);
    assign s1         = sgn & Rdata1[31];
    assign s2         = sgn & Rdata2[31];

    assign Busy  = busy;
    assign HIout = hi_q;
    assign LOout = lo_q;

    mdu_step #(
        .STEP_BITS (STEP_BITS)
    ) u_step (
        .div_i  (state_q == MDU_DIV),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (step_acc),
        .q_o    (step_q)
    );

    // Divide shifts zeros into the low end; the new quotient bits land there.
    assign acc_d = step_acc | 64'(step_q);

    assign prod = neg_q  ? -acc_q         : acc_q;
    assign quo  = neg_q  ? -acc_q[31:0]   : acc_q[31:0];
    assign rem  = rneg_q ? -acc_q[63:32]  : acc_q[63:32];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= MDU_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dzhi_q   <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            unique case (state_q)
                MDU_IDLE: begin
                    if (accept) begin
                        case (funct)
                            MTHI: hi_q <= Rdata1;
                            MTLO: lo_q <= Rdata1;
                            MULT, MULTU: begin
                                acc_q    <= {32'b0, mag(Rdata2, sgn)};
                                opnd_q   <= mag(Rdata1, sgn);
                                neg_q    <= s1 ^ s2;
                                rneg_q   <= 1'b0;
                                dz_q     <= 1'b0;
                                is_div_q <= 1'b0;
                                cnt_q    <= 6'(N);
                                state_q  <= MDU_MUL;
                            end
                            DIV, DIVU: begin
                                acc_q    <= {32'b0, mag(Rdata1, sgn)};
                                opnd_q   <= mag(Rdata2, sgn);
                                neg_q    <= s1 ^ s2;
                                rneg_q   <= s1;
                                dz_q     <= (Rdata2 == 32'b0);
                                dzhi_q   <= Rdata1;
                                is_div_q <= 1'b1;
                                cnt_q    <= 6'(N);
                                state_q  <= MDU_DIV;
                            end
                            default: ;
                        endcase
                    end
                end
                MDU_MUL, MDU_DIV: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        state_q <= MDU_FIX;
                    end
                end
                MDU_FIX: begin
                    if (!is_div_q) begin
                        hi_q <= prod[63:32];
                        lo_q <= prod[31:0];
                    end else if (dz_q) begin
                        hi_q <= dzhi_q;
                        lo_q <= DIV0_QUO;
                    end else begin
                        hi_q <= rem;
                        lo_q <= quo;
                    end
                    state_q <= MDU_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: results are queued at issue and
// checked by a monitor whenever Busy falls.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] Ins = '0;
    logic        InsValid = 1'b0;
    logic [31:0] Rdata1 = '0;
    logic [31:0] Rdata2 = '0;
    logic [31:0] HIout;
    logic [31:0] LOout;
    logic        Busy;
    logic        Stall;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];

    mdu_ctrl #(
        .STEP_BITS (1)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Ins      (Ins),
        .InsValid (InsValid),
        .Rdata1   (Rdata1),
        .Rdata2   (Rdata2),
        .HIout    (HIout),
        .LOout    (LOout),
        .Busy     (Busy),
        .Stall    (Stall)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] rins(input logic [5:0] f);
        return {26'b0, f};
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic expect_res(input string nm, input logic [31:0] hi,
                              input logic [31:0] lo, input int cyc);
        exp_t e;
        e.hi = hi;
        e.lo = lo;
        e.cyc = cyc;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b);
        Ins = rins(f);
        Rdata1 = a;
        Rdata2 = b;
        InsValid = 1'b1;
        @(posedge CLK);
        #1;
        InsValid = 1'b0;
        Ins = '0;
        Rdata1 = $urandom;
        Rdata2 = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (Busy) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: Busy still %b after %0d cycles", Busy, n);
        end
    endtask

    task automatic mdu_op(input string nm, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo);
        expect_res(nm, hi, lo, 33);
        issue(f, a, b);
        wait_idle();
    endtask

    // Monitor: each falling edge of Busy retires one scoreboard entry.
    initial begin
        logic bprev;
        int   bcnt;
        exp_t e;
        bprev = 1'b0;
        bcnt = 0;
        forever begin
            @(negedge CLK);
            if (bprev && !Busy) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: HI %h LO %h, no entry queued",
                             HIout, LOout);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_hi"}, HIout, e.hi);
                    check({e.name, "_lo"}, LOout, e.lo);
                    if (e.cyc > 0) begin
                        check({e.name, "_busy_cycles"}, 32'(bcnt), 32'(e.cyc));
                    end
                end
                bcnt = 0;
            end
            if (Busy) bcnt++;
            bprev = Busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("rst_hi", HIout, 32'h0);
        check("rst_lo", LOout, 32'h0);
        check("rst_busy", 32'(Busy), 32'h0);
        Ins = rins(MFHI);
        InsValid = 1'b1;
        #1;
        check("rst_stall", 32'(Stall), 32'h0);
        InsValid = 1'b0;

        mdu_op("mult_neg3x7", MULT, 32'hFFFF_FFFD, 32'd7,
               32'hFFFF_FFFF, 32'hFFFF_FFEB);
        mdu_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001);
        mdu_op("div_neg7by2", DIV, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        mdu_op("divu_by0", DIVU, 32'd5, 32'd0,
               32'h0000_0005, 32'hFFFF_FFFF);
        mdu_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000);
        mdu_op("div_7byneg2", DIV, 32'd7, 32'hFFFF_FFFE,
               32'h0000_0001, 32'hFFFF_FFFD);
        mdu_op("divu_100by7", DIVU, 32'd100, 32'd7,
               32'h0000_0002, 32'h0000_000E);
        mdu_op("div_neg9by0", DIV, 32'hFFFF_FFF7, 32'd0,
               32'hFFFF_FFF7, 32'hFFFF_FFFF);
        mdu_op("mult_minsq", MULT, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 32'h0000_0000);
        mdu_op("mult_byneg1", MULT, 32'h1234_5678, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, 32'hEDCB_A988);

        // MTLO / MTHI take effect on the next edge with no stall.
        Ins = rins(MTLO);
        Rdata1 = 32'h0000_1234;
        InsValid = 1'b1;
        #1;
        check("mtlo_stall", 32'(Stall), 32'h0);
        @(posedge CLK);
        #1;
        InsValid = 1'b0;
        @(negedge CLK);
        check("mtlo_lo", LOout, 32'h0000_1234);
        check("mtlo_hi_kept", HIout, 32'hFFFF_FFFF);

        issue(MTHI, 32'hCAFE_F00D, 32'h0);
        @(negedge CLK);
        check("mthi_hi", HIout, 32'hCAFE_F00D);

        // Same funct under a non-R opcode must be ignored.
        issue(6'h00, 32'h0, 32'h0);
        Ins = {6'h08, 20'h0, MTLO};
        Rdata1 = 32'hDEAD_BEEF;
        InsValid = 1'b1;
        @(posedge CLK);
        #1;
        InsValid = 1'b0;
        @(negedge CLK);
        check("nonmdu_lo", LOout, 32'h0000_1234);

        // MFHI held behind a MULT.
        expect_res("mfhi_mult", 32'h0000_0001, 32'hFFFF_FFFE, 33);
        issue(MULTU, 32'hFFFF_FFFF, 32'd2);
        Ins = rins(MFHI);
        InsValid = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            if (Stall) n++;
        end while (Stall && n < 60);
        check("mfhi_stall_cycles", 32'(n), 32'd33);
        check("mfhi_busy_low", 32'(Busy), 32'h0);
        check("mfhi_hi", HIout, 32'h0000_0001);
        @(posedge CLK);
        #1;
        InsValid = 1'b0;

        // Non-MDU op during Busy is not stalled; a second MULT is.
        expect_res("b2b_first", 32'h0, 32'd15, 33);
        expect_res("b2b_second", 32'h0, 32'd42, 33);
        issue(MULT, 32'd3, 32'd5);
        Ins = {6'h08, 20'h0, MULT};
        InsValid = 1'b1;
        #1;
        check("nonmdu_busy_stall", 32'(Stall), 32'h0);
        Ins = rins(MULTU);
        Rdata1 = 32'd6;
        Rdata2 = 32'd7;
        n = 0;
        do begin
            @(negedge CLK);
            if (Stall) n++;
        end while (Stall && n < 60);
        check("b2b_stall_cycles", 32'(n), 32'd33);
        @(posedge CLK);
        #1;
        InsValid = 1'b0;
        Rdata1 = $urandom;
        Rdata2 = $urandom;
        wait_idle();

        // Reset at iteration 10 of a divide.
        expect_res("rst_abort", 32'h0, 32'h0, 0);
        issue(DIV, 32'd1000, 32'd3);
        repeat (9) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("abort_busy", 32'(Busy), 32'h0);
        mdu_op("post_rst_multu", MULTU, 32'd2, 32'd3, 32'h0, 32'd6);

        repeat (3) @(negedge CLK);
        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide controller that owns the HI/LO register pair for the EX stage. Decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the instruction word and sequences an iterative shift-add multiplier and restoring divider over several cycles. Exposes HI/LO to the ALU result path and raises a stall to the pipeline while a HI/LO consumer or a new multiply/divide meets an operation in flight. Replaces the single-cycle HI/LO update in EX.

## Interface
- STEP_BITS, 1, bits retired per iteration; legal values 1 or 2; iteration count N = 32/STEP_BITS
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- Ins  in  32  instruction in EX; opcode Ins[31:26], funct Ins[5:0]
- InsValid  in  1  Ins/Rdata are a real issued instruction this cycle
- Rdata1  in  32  rs operand (dividend / multiplicand / MTxx source)
- Rdata2  in  32  rt operand (divisor / multiplier)
- HIout  out  32  architectural HI
- LOout  out  32  architectural LO
- Busy  out  1  multiply/divide in flight
- Stall  out  1  combinational; pipeline must hold Ins this cycle

## Operation
- An op is an MDU op when Ins[31:26]==R_FORM and funct ∈ {MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO}. Non-MDU ops are ignored.
- Stall = InsValid & Busy & (MDU op). No MDU op is accepted while Stall is high.
- States: IDLE, MUL, DIV, FIX.
- IDLE, accept (InsValid, MDU op, not stalled):
  - MTHI: HI<=Rdata1. MTLO: LO<=Rdata1. Stay IDLE.
  - MFHI/MFLO: no state change; the ALU reads HIout/LOout.
  - MULT/MULTU: latch operands, count<=N, go to MUL. For MULT, latch |Rdata1| and |Rdata2| and record the result sign = sign1 XOR sign2.
  - DIV/DIVU: latch operands, count<=N, go to DIV. For DIV, latch magnitudes, quotient sign = sign1 XOR sign2, remainder sign = sign1.
- MUL: each cycle, 64-bit accumulator += multiplicand shifted by multiplier bit(s), STEP_BITS bits per cycle; count-=1; at count==1 go to FIX.
- DIV: restoring division, STEP_BITS quotient bits per cycle; count-=1; at count==1 go to FIX.
- FIX: apply sign correction (two's-complement negate where the recorded sign is set). Write HI/LO:
  - Multiply: HI = upper 32 bits, LO = lower 32 bits.
  - Divide: LO = quotient, HI = remainder.
  - Go to IDLE.
- Signed divide: quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (both signed and unsigned): LO=32'hFFFFFFFF, HI=Rdata1 as issued. Sequence length is unchanged.
- DIV 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0.
- Busy = state ≠ IDLE.

## Timing
- Reset: state=IDLE, HIout=0, LOout=0, Busy=0, count=0. Stall is therefore 0.
- RST asserted mid-operation: the operation is aborted, HI/LO are cleared to 0, and the block is IDLE on the next cycle.
- MTHI/MTLO accepted at edge k: HIout/LOout show the new value after edge k.
- MULT/DIV accepted at edge k:
  - Busy is high after edge k.
  - HI/LO are written at edge k+N+1 (N iterations plus FIX).
  - Busy falls after edge k+N+1.
  - With STEP_BITS=1, latency is 33 cycles.
- MFHI issued on the cycle Busy falls is not stalled and reads the new value.
- Back-to-back MULTs: the second is stalled for N+1 cycles, then accepted.
- Operands are sampled only at accept; Rdata changes during Busy have no effect.
- HI/LO hold their old values throughout MUL/DIV. There are no partial updates.

## Structure
- Opcode and funct constants (R_FORM, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO) come from common_param.vh.
- Add the MDU state encodings (MDU_IDLE, MDU_MUL, MDU_DIV, MDU_FIX) and the divide-by-zero quotient constant to common_param.vh.
- One sub-module, mdu_step: combinational single-iteration datapath. Inputs are mode, accumulator/remainder, and operand; outputs are the next accumulator/remainder and quotient bits. mdu_ctrl holds all registers, the counter and the FSM.

## Test plan
- MULT Rdata1=-3 (FFFFFFFD), Rdata2=7 -> after 33 cycles HI=FFFFFFFF, LO=FFFFFFEB; Busy high exactly 33 cycles.
- MULTU FFFFFFFF×FFFFFFFF -> HI=FFFFFFFE, LO=00000001.
- DIV -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF.
- DIVU 5/0 -> LO=FFFFFFFF, HI=00000005.
- DIV 80000000/FFFFFFFF -> LO=80000000, HI=0.
- MFHI issued 1 cycle after MULT -> Stall high for 33 cycles, then low in the cycle Busy falls, with HIout already equal to the product high word.
- MTLO 1234 in IDLE -> LOout=1234 next cycle, no stall.
- RST at iteration 10 of a DIV -> next cycle Busy=0, HI=LO=0, and a following MULTU 2×3 yields LO=6.
